// File: rtl/jstk_spi_slave_pkg.sv
// jstk_spi_slave_pkg: shared frame geometry, FSM encoding and joystick byte map
package jstk_spi_slave_pkg;
  localparam int FRAME_BYTES_DEF = 5;
  localparam int X_LO = 0;
  localparam int X_HI = 1;
  localparam int Y_LO = 2;
  localparam int Y_HI = 3;
  localparam int BTN = 4;
  typedef enum logic [1:0] {ARM, IDLE, SHIFT} state_t;
  function automatic int frame_width(input int bytes);
    return 8 * bytes;
  endfunction
endpackage

// File: rtl/jstk_spi_slave_spi_in_sync.sv
// spi_in_sync: multi-flop input synchronizer with registered rise/fall pulses
module spi_in_sync #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic hist;
  // shift the pin through the chain; edges compare the synced value with its history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {STAGES{RST_VAL}};
      hist <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      hist <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~hist;
      fall <= ~sync[STAGES-1] & hist;
    end
  end
  assign q = sync[STAGES-1];
endmodule

// File: rtl/jstk_spi_slave.sv
// jstk_spi_slave: oversampled SPI mode-0 slave emulating the PmodJSTK frame
module jstk_spi_slave
  import jstk_spi_slave_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sclk,
  input  logic                     ss,
  input  logic                     mosi,
  output logic                     miso,
  output logic                     miso_oe,
  input  logic [8*FRAME_BYTES-1:0] tx_data,
  output logic [8*FRAME_BYTES-1:0] rx_data,
  output logic                     rx_valid,
  output logic                     busy,
  output logic                     frame_err
);
  localparam int FW = frame_width(FRAME_BYTES);
  localparam int CW = $clog2(FW + 1);
  localparam int SETTLE = SYNC_STAGES + 2;
  localparam int AW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] FW_C = CW'(FW);
  localparam logic [AW-1:0] SETTLE_C = AW'(SETTLE);
  logic sclk_q, sclk_rise, sclk_fall, ss_q, ss_rise, ss_fall, mosi_q, mosi_rise, mosi_fall;
  logic unused;
  state_t state, state_n;
  logic [FW-1:0] tx_shift, tx_n, rx_shift, rx_n, rxd_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] arm_cnt, arm_n;
  logic ovr, ovr_n, miso_n, rxv_n, ferr_n;
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst_n(rst_n), .d(ss), .q(ss_q), .rise(ss_rise), .fall(ss_fall)
  );
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );
  assign unused = ^{sclk_q, mosi_rise, mosi_fall};
  assign busy = state == SHIFT;
  assign miso_oe = busy;
  // next state and datapath; ARM waits for the reset-valued SS chain to flush before trusting SS
  always_comb begin
    state_n = state;
    tx_n = tx_shift;
    rx_n = rx_shift;
    cnt_n = cnt;
    ovr_n = ovr;
    miso_n = miso;
    rxd_n = rx_data;
    rxv_n = 1'b0;
    ferr_n = 1'b0;
    arm_n = arm_cnt;
    case (state)
      ARM: begin
        arm_n = (arm_cnt == SETTLE_C) ? arm_cnt : arm_cnt + 1'b1;
        state_n = (arm_cnt == SETTLE_C && ss_q) ? IDLE : ARM;
      end
      IDLE: if (ss_fall) begin
        state_n = SHIFT;
        tx_n = tx_data;
        miso_n = tx_data[FW-1];
        rx_n = '0;
        cnt_n = '0;
        ovr_n = 1'b0;
      end
      SHIFT: if (ss_rise) begin
        state_n = IDLE;
        miso_n = 1'b0;
        rxv_n = cnt == FW_C && !ovr;
        ferr_n = !(cnt == FW_C && !ovr);
        rxd_n = rxv_n ? rx_shift : rx_data;
      end else if (sclk_rise) begin
        rx_n = (cnt < FW_C) ? {rx_shift[FW-2:0], mosi_q} : rx_shift;
        cnt_n = (cnt < FW_C) ? cnt + 1'b1 : cnt;
        ovr_n = ovr | (cnt == FW_C);
      end else if (sclk_fall) begin
        tx_n = (cnt < FW_C) ? {tx_shift[FW-2:0], 1'b0} : tx_shift;
        miso_n = (cnt < FW_C) ? tx_shift[FW-2] : 1'b0;
      end
      default: state_n = ARM;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARM;
      tx_shift <= '0;
      rx_shift <= '0;
      cnt <= '0;
      ovr <= 1'b0;
      miso <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      arm_cnt <= '0;
    end else begin
      state <= state_n;
      tx_shift <= tx_n;
      rx_shift <= rx_n;
      cnt <= cnt_n;
      ovr <= ovr_n;
      miso <= miso_n;
      rx_data <= rxd_n;
      rx_valid <= rxv_n;
      frame_err <= ferr_n;
      arm_cnt <= arm_n;
    end
  end
endmodule

// File: tb/tb_jstk_spi_slave.sv
// tb_jstk_spi_slave: randomized frame-level checks of the joystick SPI slave
module tb_jstk_spi_slave;
  import jstk_spi_slave_pkg::*;
  logic clk = 0, rst_n = 0, sclk = 0, ss = 1, mosi = 0;
  logic miso, miso_oe, rx_valid, busy, frame_err;
  logic [39:0] tx_data = '0, rx_data;
  logic [39:0] exp_rx = '0;
  int n_cmp = 0, n_fail = 0, n_valid = 0, n_err = 0;
  always #5 clk = ~clk;
  jstk_spi_slave dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
    .miso_oe(miso_oe), .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .frame_err(frame_err)
  );
  always @(negedge clk) begin
    if (rx_valid) n_valid++;
    if (frame_err) n_err++;
  end
  task automatic clkw(input int n);
    repeat (n) @(negedge clk);
  endtask
  // master side of one frame: nbits SCLK clocks, optional TX_DATA change and SS/SCLK coincidence
  task automatic run_frame(input logic [39:0] tx, input logic [39:0] mo, input int nbits,
                           input int half, input int chg_at, input logic [39:0] tx2,
                           input bit coinc, output logic [39:0] got, output bit extra_ok,
                           output bit act_ok);
    got = '0;
    extra_ok = 1;
    act_ok = 1;
    tx_data = tx;
    clkw(4);
    ss = 0;
    clkw(half);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_at) tx_data = tx2;
      mosi = (i < 40) ? mo[39-i] : 1'($urandom);
      clkw(half);
      if (i < 40) got[39-i] = miso;
      else if (miso !== 1'b0) extra_ok = 0;
      if (busy !== 1'b1 || miso_oe !== 1'b1) act_ok = 0;
      sclk = 1;
      clkw(half);
      sclk = 0;
    end
    clkw(half);
    if (coinc) begin
      sclk = 1;
      ss = 1;
      clkw(half);
      sclk = 0;
    end else ss = 1;
    clkw(12);
  endtask
  task automatic test_reset;
    clkw(3);
    n_cmp++;
    if ({miso, miso_oe, busy, rx_valid, frame_err} !== 5'b0 || rx_data !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_outputs miso/oe/busy/v/err=%b rx=%h, want 00000 rx=0",
               {miso, miso_oe, busy, rx_valid, frame_err}, rx_data);
    end
    rst_n = 1;
    clkw(12);
    n_cmp++;
    if (busy !== 1'b0 || miso_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset busy=%b oe=%b, want 0 0", busy, miso_oe);
    end
  endtask
  task automatic test_slow_frame;
    logic [39:0] got, tx, mo;
    bit eo, ao;
    int v0, e0;
    tx = '0;
    tx[39-8*X_LO -: 8] = 8'hA5;
    tx[39-8*X_HI -: 8] = 8'h01;
    tx[39-8*Y_LO -: 8] = 8'h3C;
    tx[39-8*Y_HI -: 8] = 8'h02;
    tx[39-8*BTN -: 8] = 8'h07;
    mo = 40'h83_11_22_33_44;
    v0 = n_valid;
    e0 = n_err;
    run_frame(tx, mo, 40, 90, -1, tx, 0, got, eo, ao);
    exp_rx = mo;
    n_cmp++;
    if (got !== 40'hA5_01_3C_02_07) begin
      n_fail++;
      $display("FAIL slow_miso got %h want a5013c0207", got);
    end
    n_cmp++;
    if (rx_data !== exp_rx) begin
      n_fail++;
      $display("FAIL slow_rx got %h want %h", rx_data, exp_rx);
    end
    n_cmp++;
    if (n_valid - v0 != 1 || n_err - e0 != 0) begin
      n_fail++;
      $display("FAIL slow_pulses valid=%0d err=%0d want 1 0", n_valid - v0, n_err - e0);
    end
    n_cmp++;
    if (!ao || busy !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b0) begin
      n_fail++;
      $display("FAIL slow_activity in_frame_ok=%0d busy=%b oe=%b miso=%b want 1 0 0 0",
               ao, busy, miso_oe, miso);
    end
  endtask
  task automatic test_bad_count(input int nbits);
    logic [39:0] got, tx, mo;
    bit eo, ao;
    int v0, e0;
    tx = {$urandom, 8'($urandom)};
    mo = {$urandom, 8'($urandom)};
    v0 = n_valid;
    e0 = n_err;
    run_frame(tx, mo, nbits, 8, -1, tx, 0, got, eo, ao);
    n_cmp++;
    if (n_valid - v0 != 0 || n_err - e0 != 1) begin
      n_fail++;
      $display("FAIL count%0d_pulses valid=%0d err=%0d want 0 1", nbits, n_valid - v0, n_err - e0);
    end
    n_cmp++;
    if (rx_data !== exp_rx) begin
      n_fail++;
      $display("FAIL count%0d_rx got %h want %h", nbits, rx_data, exp_rx);
    end
    n_cmp++;
    if ((got >> (40 - nbits)) !== (tx >> (40 - nbits)) && nbits < 40) begin
      n_fail++;
      $display("FAIL count%0d_miso got %h want %h", nbits, got, tx);
    end else if (nbits > 40 && (got !== tx || !eo)) begin
      n_fail++;
      $display("FAIL count%0d_miso got %h tail_zero=%0d want %h 1", nbits, got, eo, tx);
    end
  endtask
  task automatic test_tx_change;
    logic [39:0] got, mo;
    bit eo, ao;
    mo = {$urandom, 8'($urandom)};
    run_frame(40'h1111111111, mo, 40, 8, 10, 40'h2222222222, 0, got, eo, ao);
    exp_rx = mo;
    n_cmp++;
    if (got !== 40'h1111111111) begin
      n_fail++;
      $display("FAIL txchg_first got %h want 1111111111", got);
    end
    mo = {$urandom, 8'($urandom)};
    run_frame(40'h2222222222, mo, 40, 8, -1, 40'h0, 0, got, eo, ao);
    exp_rx = mo;
    n_cmp++;
    if (got !== 40'h2222222222 || rx_data !== exp_rx) begin
      n_fail++;
      $display("FAIL txchg_second miso %h rx %h want 2222222222 %h", got, rx_data, exp_rx);
    end
  endtask
  task automatic test_rst_mid;
    logic [39:0] got, tx, mo;
    bit eo, ao, quiet;
    int v0, e0;
    tx_data = 40'hFFFFFFFFFF;
    v0 = n_valid;
    e0 = n_err;
    clkw(4);
    ss = 0;
    clkw(8);
    for (int i = 0; i < 17; i++) begin
      mosi = 1'($urandom);
      clkw(8);
      sclk = 1;
      clkw(8);
      sclk = 0;
    end
    rst_n = 0;
    clkw(3);
    exp_rx = '0;
    n_cmp++;
    if (rx_data !== exp_rx || busy !== 1'b0 || miso !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_in_reset rx=%h busy=%b miso=%b want 0 0 0", rx_data, busy, miso);
    end
    rst_n = 1;
    quiet = 1;
    for (int i = 0; i < 23; i++) begin
      clkw(8);
      if (busy !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b0) quiet = 0;
      sclk = 1;
      clkw(8);
      sclk = 0;
    end
    clkw(8);
    n_cmp++;
    if (!quiet || n_valid - v0 != 0 || n_err - e0 != 0) begin
      n_fail++;
      $display("FAIL rstmid_quiet quiet=%0d valid=%0d err=%0d want 1 0 0", quiet,
               n_valid - v0, n_err - e0);
    end
    ss = 1;
    clkw(20);
    tx = {$urandom, 8'($urandom)};
    mo = {$urandom, 8'($urandom)};
    run_frame(tx, mo, 40, 8, -1, tx, 0, got, eo, ao);
    exp_rx = mo;
    n_cmp++;
    if (got !== tx || rx_data !== exp_rx || n_valid - v0 != 1 || n_err - e0 != 0) begin
      n_fail++;
      $display("FAIL rstmid_next miso %h rx %h v=%0d e=%0d want %h %h 1 0", got, rx_data,
               n_valid - v0, n_err - e0, tx, exp_rx);
    end
  endtask
  task automatic test_coincident;
    logic [39:0] got, tx, mo;
    bit eo, ao;
    int v0, e0;
    tx = {$urandom, 8'($urandom)};
    mo = {$urandom, 8'($urandom)};
    v0 = n_valid;
    e0 = n_err;
    run_frame(tx, mo, 40, 8, -1, tx, 1, got, eo, ao);
    exp_rx = mo;
    n_cmp++;
    if (n_valid - v0 != 1 || n_err - e0 != 0 || rx_data !== exp_rx) begin
      n_fail++;
      $display("FAIL coincident valid=%0d err=%0d rx=%h want 1 0 %h", n_valid - v0,
               n_err - e0, rx_data, exp_rx);
    end
  endtask
  task automatic test_random;
    logic [39:0] got, tx, mo;
    bit eo, ao;
    int v0, e0, nb, ev;
    for (int k = 0; k < 8; k++) begin
      nb = ($urandom_range(0, 2) == 0) ? 38 + $urandom_range(0, 4) : 40;
      tx = {$urandom, 8'($urandom)};
      mo = {$urandom, 8'($urandom)};
      v0 = n_valid;
      e0 = n_err;
      run_frame(tx, mo, nb, $urandom_range(6, 11), -1, tx, 0, got, eo, ao);
      ev = (nb == 40) ? 1 : 0;
      if (nb == 40) exp_rx = mo;
      n_cmp++;
      if (n_valid - v0 != ev || n_err - e0 != 1 - ev || rx_data !== exp_rx ||
          (got >> (40 - (nb < 40 ? nb : 40))) !== (tx >> (40 - (nb < 40 ? nb : 40))) || !eo) begin
        n_fail++;
        $display("FAIL random%0d nb=%0d v=%0d e=%0d rx=%h miso=%h tail=%0d want v=%0d rx=%h miso=%h",
                 k, nb, n_valid - v0, n_err - e0, rx_data, got, eo, ev, exp_rx, tx);
      end
    end
  endtask
  initial begin
    test_reset;
    test_slow_frame;
    test_bad_count(39);
    test_bad_count(41);
    test_tx_change;
    test_rst_mid;
    test_coincident;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
